fft_bitrev_reorder: RTL and testbench

//  Read-side companion of the SDF radix-2 butterfly chain. It accepts one complex sample per cycle
//  in bit-reversed FFT output order and emits each frame in natural bin order (0..N-1).
//  It uses a ping-pong buffer of two N-entry banks with a valid/ready handshake on the output.
//  It sits between the last butterfly stage and the downstream consumer (magnitude, DMA, ...).

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_bank_ram.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 135 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT read-side reorder logic.
//   bitrev  : reverses the low n_log2 bits of an index (bits above are returned as 0)
//   cplx_t  : complex sample {re, im} at the default last-stage width
//   N       : default frame size
package fft_pkg;

    localparam int N_LOG2_DEF = 4;
    localparam int N          = 2 ** N_LOG2_DEF;
    localparam int DW_DEF     = 14;
    localparam int IDX_MAX_W  = 16;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    // Shifting idx[0] in first leaves it in the top used bit, which is the reversal.
    function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] idx,
                                                    input int n_log2);
        logic [IDX_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < IDX_MAX_W; i++) begin
            if (i < n_log2) begin
                r = {r[IDX_MAX_W-2:0], idx[i]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One frame bank of the ping-pong reorder buffer: 2**N_LOG2 words of {re, im}.
//   clk   : clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address (arrival order)
//   wdata : {re, im}
//   raddr : read address
//   rdata : combinational read of the word at raddr
// Contents are deliberately not reset; a frame is only read after it was fully written.
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter int DW     = 14,
    parameter int N_LOG2 = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [N_LOG2-1:0]   waddr,
    input  logic [2*DW-1:0]     wdata,
    input  logic [N_LOG2-1:0]   raddr,
    output logic [2*DW-1:0]     rdata
);

    logic [2*DW-1:0] mem [2**N_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders frames from the SDF butterfly chain (bit-reversed order, one sample per
// cycle, no stall) into natural bin order, using two frame banks in ping-pong.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/re/im      : input sample; dropped (and ovf set) when in_ready is low
//   in_ready            : the bank currently being written is free
//   out_valid/out_ready : output handshake; output registers hold while stalled
//   out_re/out_im       : sample of bin out_idx
//   out_sof/out_last    : out_idx is 0 / N-1
//   ovf                 : sticky dropped-sample flag, cleared only by rst
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DW     = 14,
    parameter int N_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DW-1:0]     in_re,
    input  logic signed [DW-1:0]     in_im,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DW-1:0]     out_re,
    output logic signed [DW-1:0]     out_im,
    output logic [N_LOG2-1:0]        out_idx,
    output logic                     out_sof,
    output logic                     out_last,
    output logic                     ovf
);

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    logic                wbank;
    logic                rbank;
    logic [N_LOG2-1:0]   wcnt;
    logic [N_LOG2-1:0]   rcnt;
    logic [1:0]          full;
    logic [1:0]          full_nxt;
    logic                accept;
    logic                wr_done;
    logic                fetch;
    logic                rd_done;
    logic [1:0]          we;
    logic [N_LOG2-1:0]   raddr;
    logic [2*DW-1:0]     rdata [2];
    logic [2*DW-1:0]     rd_sel;

    // Write side: the writer only ever targets a bank that is not full, and the
    // reader only reads a full one, so the two never share a bank.
    assign in_ready = !full[wbank];
    assign accept   = in_valid && in_ready;
    assign wr_done  = accept && (wcnt == CNT_LAST);
    assign we[0]    = accept && !wbank;
    assign we[1]    = accept && wbank;

    // Read side: natural bin rcnt lives at arrival position bitrev(rcnt).
    assign fetch    = full[rbank] && (!out_valid || out_ready);
    assign rd_done  = fetch && (rcnt == CNT_LAST);
    assign raddr    = N_LOG2'(bitrev(IDX_MAX_W'(rcnt), N_LOG2));
    assign rd_sel   = rdata[rbank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank_ram #(
            .DW     (DW),
            .N_LOG2 (N_LOG2)
        ) u_bank (
            .clk   (clk),
            .we    (we[b]),
            .waddr (wcnt),
            .wdata ({in_re, in_im}),
            .raddr (raddr),
            .rdata (rdata[b])
        );
    end

    // Completing one bank and releasing the other in the same cycle are independent.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wbank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank <= 1'b0;
            wcnt  <= '0;
            full  <= '0;
            ovf   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == CNT_LAST) begin
                    wbank <= !wbank;
                end
            end
            if (in_valid && !in_ready) begin
                ovf <= 1'b1;
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            rbank     <= 1'b0;
            rcnt      <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
        end else if (fetch) begin
            out_valid <= 1'b1;
            out_re    <= $signed(rd_sel[2*DW-1:DW]);
            out_im    <= $signed(rd_sel[DW-1:0]);
            out_idx   <= rcnt;
            out_sof   <= (rcnt == '0);
            out_last  <= (rcnt == CNT_LAST);
            rcnt      <= rcnt + 1'b1;
            if (rcnt == CNT_LAST) begin
                rbank <= !rbank;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder (DW=14, N_LOG2=4): directed frames with literal
// expectations plus randomized traffic, all against a queue-based reference model.
module tb_fft_bitrev_reorder;

    localparam int DW = 14;
    localparam int NL = 4;
    localparam int N  = 16;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 in_valid  = 1'b0;
    logic signed [DW-1:0] in_re     = '0;
    logic signed [DW-1:0] in_im     = '0;
    logic                 out_ready = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [NL-1:0]        out_idx;
    logic                 out_sof;
    logic                 out_last;
    logic                 ovf;

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.DW(DW), .N_LOG2(NL)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int i = 0; i < NL; i++)
            if ((k >> i) & 1) r |= 1 << (NL - 1 - i);
        return r;
    endfunction

    // Reference model: completed frames become a queue of samples in natural order;
    // an output slot takes the next sample whenever it is empty or being consumed.
    // Two completed-but-not-fully-fetched frames exhaust the buffer.
    typedef struct { int re; int im; int idx; } smp_t;
    smp_t avail_q[$];
    smp_t slot;
    int   part_re [N];
    int   part_im [N];
    int   wpos    = 0;
    int   pending = 0;
    bit   m_ovf   = 1'b0;
    bit   slot_v  = 1'b0;

    task automatic model_step();
        bit acc;
        bit can_fetch;
        if (rst) begin
            avail_q.delete();
            wpos    = 0;
            pending = 0;
            m_ovf   = 1'b0;
            slot_v  = 1'b0;
            slot    = '{0, 0, 0};
            return;
        end
        acc       = in_valid && (pending < 2);
        can_fetch = (avail_q.size() > 0) && (!slot_v || out_ready);
        if (in_valid && !acc) m_ovf = 1'b1;
        if (can_fetch) begin
            slot   = avail_q.pop_front();
            slot_v = 1'b1;
            if (slot.idx == N - 1) pending--;
        end else if (out_ready) begin
            slot_v = 1'b0;
        end
        if (acc) begin
            part_re[wpos] = int'(in_re);
            part_im[wpos] = int'(in_im);
            if (wpos == N - 1) begin
                for (int n = 0; n < N; n++)
                    avail_q.push_back('{part_re[brev(n)], part_im[brev(n)], n});
                pending++;
                wpos = 0;
            end else begin
                wpos++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit cmp_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("in_ready", in_ready, pending < 2);
            chk("ovf", ovf, m_ovf);
            chk("out_valid", out_valid, slot_v);
            if (slot_v) begin
                chk("out_re", out_re, slot.re);
                chk("out_im", out_im, slot.im);
                chk("out_idx", out_idx, slot.idx);
                chk("out_sof", out_sof, slot.idx == 0);
                chk("out_last", out_last, slot.idx == N - 1);
            end
        end
    end

    task automatic step(input bit v, input int re, input int im, input bit rdy);
        in_valid  = v;
        in_re     = DW'(re);
        in_im     = DW'(im);
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_re"},    out_re,    0);
        chk({tag, "_out_im"},    out_im,    0);
        chk({tag, "_out_idx"},   out_idx,   0);
        chk({tag, "_out_sof"},   out_sof,   0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_ovf"},       ovf,       0);
        chk({tag, "_in_ready"},  in_ready,  1);
    endtask

    int first_c;
    int last_c;
    int cnt;
    int hs;

    initial begin
        do_reset();
        cmp_en = 1'b1;
        chk_reset_state("rst0");

        // 1: single frame, literal output values and latency
        for (int k = 0; k < N; k++) step(1'b1, 16 * brev(k), -k, 1'b1);
        chk("t1_latency", out_valid, 0);
        for (int n = 0; n < N; n++) begin
            step(1'b0, 0, 0, 1'b1);
            chk("t1_valid", out_valid, 1);
            chk("t1_re", out_re, 16 * n);
            chk("t1_im", out_im, -brev(n));
            chk("t1_idx", out_idx, n);
            chk("t1_sof", out_sof, n == 0);
            chk("t1_last", out_last, n == N - 1);
        end
        step(1'b0, 0, 0, 1'b1);
        chk("t1_end", out_valid, 0);

        // 2: two frames back-to-back, continuous output
        first_c = -1;
        last_c  = -1;
        cnt     = 0;
        for (int c = 0; c < 72; c++) begin
            if (c < 2 * N) step(1'b1, c * 3 - 50, 7 - c, 1'b1);
            else           step(1'b0, 0, 0, 1'b1);
            if (out_valid) begin
                cnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        chk("t2_count", cnt, 32);
        chk("t2_span", last_c - first_c + 1, 32);
        chk("t2_first", first_c, 16);
        chk("t2_ovf", ovf, 0);

        // 3: out_ready toggling, each sample delivered exactly once in order
        for (int k = 0; k < N; k++) step(1'b1, 500 + k, -(500 + k), 1'b0);
        hs = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid && (c % 2 == 0)) begin
                chk("t3_idx", out_idx, hs);
                chk("t3_re", out_re, 500 + brev(hs));
                hs++;
            end
            step(1'b0, 0, 0, 1'(c % 2 == 0));
        end
        chk("t3_count", hs, 16);

        // 4: consumer stalled over three frames, third frame dropped
        for (int k = 0; k < 3 * N; k++) begin
            step(1'b1, (k / N) * 100 + (k % N), -((k / N) * 100 + (k % N)), 1'b0);
            if (k == 2 * N - 1) begin
                chk("t4_in_ready", in_ready, 0);
                chk("t4_ovf_before", ovf, 0);
            end
        end
        chk("t4_ovf", ovf, 1);
        hs = 0;
        for (int c = 0; c < 80; c++) begin
            if (out_valid) begin
                chk("t4_idx", out_idx, hs % N);
                chk("t4_re", out_re, (hs / N) * 100 + brev(hs % N));
                hs++;
            end
            step(1'b0, 0, 0, 1'b1);
        end
        chk("t4_count", hs, 32);
        chk("t4_in_ready_after", in_ready, 1);

        // 5: reset mid-frame and mid-readout
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, k, k, 1'b1);
        do_reset();
        chk_reset_state("t5a");
        for (int k = 0; k < N; k++) step(1'b1, -200 + k, k, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 0, 0, 1'b1);
        do_reset();
        chk_reset_state("t5b");
        for (int k = 0; k < N; k++) step(1'b1, 300 + k, -k, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        chk("t5_first_idx", out_idx, 0);
        chk("t5_first_sof", out_sof, 1);
        chk("t5_first_re", out_re, 300);
        for (int c = 0; c < N + 2; c++) step(1'b0, 0, 0, 1'b1);

        // 6: random input gaps and random consumer stalls
        do_reset();
        for (int c = 0; c < 3000; c++)
            step(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 16383)) - 8192,
                 1'($urandom_range(0, 7) != 0));
        for (int c = 0; c < 60; c++) step(1'b0, 0, 0, 1'b1);
        chk("t6_ovf", ovf, 0);
        chk("t6_drained", out_valid, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
